interleave_sequencer: RTL

Sequential controller that feeds the combinational 4-byte `interleaver` from a byte stream and returns its result as a byte stream. It sits between a byte-serial producer (e.g. a UART/encoder front end) and a byte-serial consumer (transmitter). It gathers four input bytes into a block, captures the interleaver outputs in one load cycle, and drains the four interleaved bytes under valid/ready flow control. The block also counts completed blocks.

---
 rtl/interleave_sequencer_pkg.sv | 16 +
 rtl/interleave_sequencer_interleaver.sv | 37 +++
 rtl/interleave_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/interleave_sequencer_pkg.sv
// interleave_pkg: shared constants for the interleave sequencer.
//   state_t / S_FILL, S_LOAD, S_DRAIN : sequencer state encoding
//   BLK_BYTES                         : bytes per interleave block
//   IDX_W                             : width of the byte index within a block
package interleave_pkg;

    localparam int BLK_BYTES = 4;
    localparam int IDX_W     = 2;

    typedef logic [1:0] state_t;

    localparam state_t S_FILL  = 2'd0;
    localparam state_t S_LOAD  = 2'd1;
    localparam state_t S_DRAIN = 2'd2;

endpackage

// File: rtl/interleave_sequencer_interleaver.sv
// interleaver: combinational 4-byte bit interleaver.
//   byte0..byte3 in  8  input block, byte0 is the first byte of the stream
//   out0..out3   out 8  interleaved block
// Output byte k gathers bit pair (2k, 2k+1) of every input byte:
//   out_k[4*h + j] = byte_j[2*k + h]
module interleaver (
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic [7:0] byte2,
    input  logic [7:0] byte3,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3
);
    logic [7:0] b [4];
    logic [7:0] o [4];

    assign b[0] = byte0;
    assign b[1] = byte1;
    assign b[2] = byte2;
    assign b[3] = byte3;

    always_comb begin
        o = '{default: 8'h00};
        for (int k = 0; k < 4; k++)
            for (int h = 0; h < 2; h++)
                for (int j = 0; j < 4; j++)
                    o[k][4*h + j] = b[j][2*k + h];
    end

    assign out0 = o[0];
    assign out1 = o[1];
    assign out2 = o[2];
    assign out3 = o[3];

endmodule

// File: rtl/interleave_sequencer.sv
// interleave_sequencer: gathers a 4-byte block from a byte stream, runs it
// through the interleaver in a single load cycle and drains the result as a
// byte stream. Fill and drain never overlap.
//   clk, reset_n          clock, synchronous active-low reset
//   in_data/valid/ready   byte input stream (transfer on valid && ready)
//   flush                 drops a partial input block (ignored outside FILL)
//   out_data/valid/ready  byte output stream (transfer on valid && ready)
//   out_last              marks the 4th byte of a block
//   busy                  anything other than an empty FILL state
//   blocks_done           count of fully drained blocks, wraps
module interleave_sequencer
    import interleave_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [CNT_W-1:0] blocks_done
);
    state_t     state;
    logic [IDX_W-1:0] idx;
    logic [7:0] blk  [BLK_BYTES];
    logic [7:0] obuf [BLK_BYTES];
    logic [7:0] ilv  [BLK_BYTES];
    logic       last_idx;
    logic       drain_done;

    interleaver u_interleaver (
        .byte0 (blk[0]),
        .byte1 (blk[1]),
        .byte2 (blk[2]),
        .byte3 (blk[3]),
        .out0  (ilv[0]),
        .out1  (ilv[1]),
        .out2  (ilv[2]),
        .out3  (ilv[3])
    );

    assign last_idx   = (idx == IDX_W'(BLK_BYTES - 1));
    assign drain_done = (state == S_DRAIN) && out_ready && last_idx;

    // All outputs decode registered state only; in_valid/out_ready never
    // reach an output combinationally.
    assign in_ready  = (state == S_FILL);
    assign out_valid = (state == S_DRAIN);
    assign out_last  = (state == S_DRAIN) && last_idx;
    assign out_data  = (state == S_DRAIN) ? obuf[idx] : 8'h00;
    assign busy      = !((state == S_FILL) && (idx == '0));

    // The input block buffer needs no reset: it is always fully rewritten
    // before LOAD reads it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_FILL;
            idx   <= '0;
            obuf  <= '{default: 8'h00};
        end else begin
            case (state)
                S_FILL: begin
                    if (flush) begin
                        idx <= '0;
                    end else if (in_valid) begin
                        blk[idx] <= in_data;
                        idx      <= idx + IDX_W'(1);
                        if (last_idx) state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < BLK_BYTES; i++) obuf[i] <= ilv[i];
                    state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        idx <= idx + IDX_W'(1);
                        if (last_idx) state <= S_FILL;
                    end
                end
                default: begin
                    state <= S_FILL;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)        blocks_done <= '0;
        else if (drain_done) blocks_done <= blocks_done + CNT_W'(1);
    end

endmodule
